s_inv_serial: RTL and testbench

S_INV_SERIAL -- requirements
Module: s_inv_serial

---
 rtl/s_inv_serial.sv | 173 +++++++++++++++++
 tb/tb_s_inv_serial.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_inv_serial.sv
// Serial 2x2 inverse of the innovation covariance S = sigma2 + R in signed QFRAC.
// A determinant pass, a bit-serial restoring reciprocal, then adjugate scaling.
module s_inv_serial #(
  parameter int N    = 20,
  parameter int FRAC = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] sigma2_00,
  input  logic signed [N-1:0] sigma2_01,
  input  logic signed [N-1:0] sigma2_10,
  input  logic signed [N-1:0] sigma2_11,
  input  logic signed [N-1:0] R11,
  input  logic signed [N-1:0] R12,
  input  logic signed [N-1:0] R21,
  input  logic signed [N-1:0] R22,
  output logic signed [N-1:0] Sinv00,
  output logic signed [N-1:0] Sinv01,
  output logic signed [N-1:0] Sinv10,
  output logic signed [N-1:0] Sinv11,
  output logic                singular,
  output logic                busy,
  output logic                done
);

  localparam int QW = 2*FRAC + 1;
  localparam int CW = $clog2(QW + 1);
  localparam int MW = (QW > N) ? QW : N;
  localparam logic [MW-1:0] SAT_MAX = MW'((64'd1 << (N-1)) - 64'd1);

  typedef enum logic [1:0] {IDLE, DET, DIV, OUT} state_t;

  state_t              r_state;
  logic signed [N-1:0] r_s00, r_s01, r_s10, r_s11;
  logic signed [N-1:0] r_det;
  logic signed [N-1:0] r_inv;
  logic        [N-1:0] r_mag;
  logic        [N-1:0] r_rem;
  logic                r_sign;
  logic       [QW-1:0] r_quot;
  logic       [CW-1:0] r_cnt;
  logic signed [N-1:0] r_sinv00, r_sinv01, r_sinv10, r_sinv11;
  logic                r_singular;
  logic                r_done;

  // Determinant of the latched S, rescaled back to QFRAC.
  logic signed [2*N-1:0] w_pDiag, w_pOff;
  logic signed [2*N:0]   w_diff;
  logic signed [N-1:0]   w_detNext;
  logic        [N-1:0]   w_detMag;

  assign w_pDiag   = (2*N)'(r_s00) * (2*N)'(r_s11);
  assign w_pOff    = (2*N)'(r_s01) * (2*N)'(r_s10);
  assign w_diff    = $signed({w_pDiag[2*N-1], w_pDiag}) - $signed({w_pOff[2*N-1], w_pOff});
  assign w_detNext = N'(w_diff >>> FRAC);
  assign w_detMag  = w_detNext[N-1] ? -w_detNext : w_detNext;

  // Restoring divide of 2^(2*FRAC) by |det|: only the first dividend bit is set.
  logic          w_dbit;
  logic [N:0]    w_remShift;
  logic          w_ge;
  logic [N-1:0]  w_remNext;
  logic [QW-1:0] w_quotNext;
  logic [MW-1:0] w_quotWide;
  logic [N-1:0]  w_qSat;
  logic signed [N-1:0] w_invNext;
  logic          w_lastIter;

  assign w_dbit     = (r_cnt == '0);
  assign w_remShift = {r_rem, w_dbit};
  assign w_ge       = (w_remShift >= {1'b0, r_mag});
  assign w_remNext  = w_ge ? N'(w_remShift - {1'b0, r_mag}) : N'(w_remShift);
  assign w_quotNext = QW'({r_quot, w_ge});
  assign w_quotWide = MW'(w_quotNext);
  assign w_qSat     = (w_quotWide > SAT_MAX) ? N'(SAT_MAX) : N'(w_quotWide);
  assign w_invNext  = r_sign ? -w_qSat : w_qSat;
  assign w_lastIter = (r_cnt == CW'(QW - 1));

  logic signed [2*N-1:0] w_m00, w_m01, w_m10, w_m11;
  logic signed [N-1:0]   w_t00, w_t01, w_t10, w_t11;

  assign w_m00 = (2*N)'(r_s11) * (2*N)'(r_inv);
  assign w_m11 = (2*N)'(r_s00) * (2*N)'(r_inv);
  assign w_m01 = (2*N)'(r_s01) * (2*N)'(r_inv);
  assign w_m10 = (2*N)'(r_s10) * (2*N)'(r_inv);
  assign w_t00 = N'(w_m00 >>> FRAC);
  assign w_t11 = N'(w_m11 >>> FRAC);
  assign w_t01 = N'(w_m01 >>> FRAC);
  assign w_t10 = N'(w_m10 >>> FRAC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_s00      <= '0;
      r_s01      <= '0;
      r_s10      <= '0;
      r_s11      <= '0;
      r_det      <= '0;
      r_inv      <= '0;
      r_mag      <= '0;
      r_rem      <= '0;
      r_sign     <= 1'b0;
      r_quot     <= '0;
      r_cnt      <= '0;
      r_sinv00   <= '0;
      r_sinv01   <= '0;
      r_sinv10   <= '0;
      r_sinv11   <= '0;
      r_singular <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_s00   <= sigma2_00 + R11;
            r_s01   <= sigma2_01 + R12;
            r_s10   <= sigma2_10 + R21;
            r_s11   <= sigma2_11 + R22;
            r_state <= DET;
          end
        end
        DET: begin
          r_det   <= w_detNext;
          r_mag   <= w_detMag;
          r_sign  <= w_detNext[N-1];
          r_rem   <= '0;
          r_quot  <= '0;
          r_cnt   <= '0;
          r_state <= (w_detNext == '0) ? OUT : DIV;
        end
        DIV: begin
          r_rem  <= w_remNext;
          r_quot <= w_quotNext;
          r_cnt  <= r_cnt + CW'(1);
          if (w_lastIter) begin
            r_inv   <= w_invNext;
            r_state <= OUT;
          end
        end
        OUT: begin
          // A zero determinant is the only way to reach OUT without dividing.
          if (r_det == '0) begin
            r_sinv00   <= '0;
            r_sinv01   <= '0;
            r_sinv10   <= '0;
            r_sinv11   <= '0;
            r_singular <= 1'b1;
          end else begin
            r_sinv00   <= w_t00;
            r_sinv11   <= w_t11;
            r_sinv01   <= -w_t01;
            r_sinv10   <= -w_t10;
            r_singular <= 1'b0;
          end
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Sinv00   = r_sinv00;
  assign Sinv01   = r_sinv01;
  assign Sinv10   = r_sinv10;
  assign Sinv11   = r_sinv11;
  assign singular = r_singular;
  assign done     = r_done;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_s_inv_serial.sv
// Bench for s_inv_serial: fixed vectors, multi-cycle corner sequences and
// random jobs checked against an integer-arithmetic model of the inverse.
module tb_s_inv_serial;

  localparam int N    = 20;
  localparam int FRAC = 10;
  localparam int LAT  = 2*FRAC + 3;

  logic clk, rst, start;
  logic signed [N-1:0] sigma2_00, sigma2_01, sigma2_10, sigma2_11;
  logic signed [N-1:0] R11, R12, R21, R22;
  logic signed [N-1:0] Sinv00, Sinv01, Sinv10, Sinv11;
  logic singular, busy, done;

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    logic signed [N-1:0] s00, s01, s10, s11, r11, r12, r21, r22;
  } jobIn_t;

  typedef struct {
    longint i00, i01, i10, i11;
    longint sing;
    int     lat;
  } expOut_t;

  typedef struct {
    string   name;
    jobIn_t  in;
    expOut_t exp;
  } vec_t;

  s_inv_serial #(.N(N), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .sigma2_00(sigma2_00), .sigma2_01(sigma2_01),
    .sigma2_10(sigma2_10), .sigma2_11(sigma2_11),
    .R11(R11), .R12(R12), .R21(R21), .R22(R22),
    .Sinv00(Sinv00), .Sinv01(Sinv01), .Sinv10(Sinv10), .Sinv11(Sinv11),
    .singular(singular), .busy(busy), .done(done)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait escapes its bound.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic longint wrapN(input longint x);
    logic [N-1:0] t;
    t = x[N-1:0];
    return longint'($signed(t));
  endfunction

  function automatic jobIn_t mkIn(input longint a, b, c, d, e, f, g, h);
    jobIn_t j;
    j.s00 = N'(a); j.s01 = N'(b); j.s10 = N'(c); j.s11 = N'(d);
    j.r11 = N'(e); j.r12 = N'(f); j.r21 = N'(g); j.r22 = N'(h);
    return j;
  endfunction

  function automatic expOut_t mkExp(input longint a, b, c, d, s, input int l);
    expOut_t e;
    e.i00 = a; e.i01 = b; e.i10 = c; e.i11 = d; e.sing = s; e.lat = l;
    return e;
  endfunction

  // Reference: S = sigma2 + R, det in QFRAC, reciprocal by integer division,
  // inverse = adj(S) * (1/det), every stored value wrapped to N bits.
  function automatic expOut_t model(input jobIn_t j);
    expOut_t e;
    longint s00, s01, s10, s11, det, mag, q, inv, qMax;
    s00 = wrapN(longint'(j.s00) + longint'(j.r11));
    s01 = wrapN(longint'(j.s01) + longint'(j.r12));
    s10 = wrapN(longint'(j.s10) + longint'(j.r21));
    s11 = wrapN(longint'(j.s11) + longint'(j.r22));
    det = wrapN((s00*s11 - s01*s10) >>> FRAC);
    if (det == 0) begin
      e = mkExp(0, 0, 0, 0, 1, 2);
    end else begin
      mag  = (det < 0) ? -det : det;
      q    = (longint'(1) << (2*FRAC)) / mag;
      qMax = (longint'(1) << (N-1)) - 1;
      if (q > qMax) q = qMax;
      inv  = (det < 0) ? -q : q;
      e.i00  = wrapN((s11*inv) >>> FRAC);
      e.i11  = wrapN((s00*inv) >>> FRAC);
      e.i01  = wrapN(-wrapN((s01*inv) >>> FRAC));
      e.i10  = wrapN(-wrapN((s10*inv) >>> FRAC));
      e.sing = 0;
      e.lat  = LAT;
    end
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic driveJob(input jobIn_t j);
    sigma2_00 = j.s00; sigma2_01 = j.s01; sigma2_10 = j.s10; sigma2_11 = j.s11;
    R11 = j.r11; R12 = j.r12; R21 = j.r21; R22 = j.r22;
    start = 1'b1;
  endtask

  // Called one negedge after start was raised: drops start and scrambles the
  // inputs so a job that resamples them would be caught.
  task automatic releaseStart();
    start = 1'b0;
    sigma2_00 = N'($urandom); sigma2_01 = N'($urandom);
    sigma2_10 = N'($urandom); sigma2_11 = N'($urandom);
    R11 = N'($urandom); R12 = N'($urandom); R21 = N'($urandom); R22 = N'($urandom);
  endtask

  task automatic applyStimulus(input jobIn_t j);
    @(negedge clk);
    driveJob(j);
    @(negedge clk);
    releaseStart();
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic checkOutput(input string tag, input expOut_t e, input int lat);
    check({tag, ".latency"}, lat, e.lat);
    check({tag, ".done"}, longint'(done), 1);
    check({tag, ".busyAtDone"}, longint'(busy), 0);
    check({tag, ".Sinv00"}, longint'(Sinv00), e.i00);
    check({tag, ".Sinv01"}, longint'(Sinv01), e.i01);
    check({tag, ".Sinv10"}, longint'(Sinv10), e.i10);
    check({tag, ".Sinv11"}, longint'(Sinv11), e.i11);
    check({tag, ".singular"}, longint'(singular), e.sing);
  endtask

  task automatic runJob(input string tag, input jobIn_t j, input expOut_t e);
    int lat;
    applyStimulus(j);
    check({tag, ".busy"}, longint'(busy), 1);
    waitDone(lat);
    checkOutput(tag, e, lat);
    @(negedge clk);
    check({tag, ".donePulse"}, longint'(done), 0);
    check({tag, ".hold00"}, longint'(Sinv00), e.i00);
  endtask

  function automatic logic signed [N-1:0] rndVal(input int mode, input bit onDiag);
    case (mode)
      0:       return N'(int'($urandom_range(4096)) - 2048);
      1:       return N'($urandom);
      default: return onDiag ? N'(int'($urandom_range(8192, 512)))
                             : N'(int'($urandom_range(256)) - 128);
    endcase
  endfunction

  vec_t    tbl[4];
  jobIn_t  rj;
  expOut_t re;
  int      lat, doneCount, firstLat, mode;

  initial begin
    tbl[0].name = "identity2"; tbl[0].in = mkIn(1024, 0, 0, 1024, 1024, 0, 0, 1024);
    tbl[0].exp  = mkExp(512, 0, 0, 512, 0, LAT);
    tbl[1].name = "allZero";   tbl[1].in = mkIn(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1].exp  = mkExp(0, 0, 0, 0, 1, 2);
    tbl[2].name = "negDet";    tbl[2].in = mkIn(0, 1024, 1024, 0, 0, 0, 0, 0);
    tbl[2].exp  = mkExp(0, 1024, 1024, 0, 0, LAT);
    tbl[3].name = "satQuot";   tbl[3].in = mkIn(32, 0, 0, 32, 0, 0, 0, 0);
    tbl[3].exp  = mkExp(16383, 0, 0, 16383, 0, LAT);

    // Reset with start held high: reset must win.
    rst = 1'b1;
    driveJob(mkIn(1024, 0, 0, 1024, 1024, 0, 0, 1024));
    repeat (3) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("reset.busy", longint'(busy), 0);
    check("reset.done", longint'(done), 0);
    check("reset.singular", longint'(singular), 0);
    check("reset.Sinv00", longint'(Sinv00), 0);
    check("reset.Sinv11", longint'(Sinv11), 0);
    @(negedge clk);
    check("reset.idleAfter", longint'(busy), 0);

    for (int i = 0; i < 4; i++) runJob(tbl[i].name, tbl[i].in, tbl[i].exp);

    // Back-to-back: a start raised while done is high is accepted.
    applyStimulus(tbl[3].in);
    waitDone(lat);
    checkOutput("b2bFirst", tbl[3].exp, lat);
    driveJob(tbl[0].in);
    @(negedge clk);
    releaseStart();
    check("b2bSecond.busy", longint'(busy), 1);
    waitDone(lat);
    checkOutput("b2bSecond", tbl[0].exp, lat);
    @(negedge clk);

    // Run satQuot so outputs are nonzero, then reset in the middle of a divide.
    runJob("preAbort", tbl[3].in, tbl[3].exp);
    applyStimulus(tbl[0].in);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", longint'(busy), 0);
    check("abort.done", longint'(done), 0);
    check("abort.Sinv00", longint'(Sinv00), 0);
    check("abort.Sinv11", longint'(Sinv11), 0);
    check("abort.singular", longint'(singular), 0);
    doneCount = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
    check("abort.noDone", doneCount, 0);

    // Fresh job with start pulses while busy: exactly one done, on time.
    applyStimulus(tbl[0].in);
    doneCount = 0;
    firstLat  = -1;
    for (int k = 1; k <= 45; k++) begin
      if (k == 6 || k == 13 || k == 22) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        doneCount++;
        if (doneCount == 1) begin
          firstLat = k;
          check("ignore.Sinv00", longint'(Sinv00), 512);
          check("ignore.Sinv01", longint'(Sinv01), 0);
          check("ignore.Sinv11", longint'(Sinv11), 512);
          check("ignore.singular", longint'(singular), 0);
        end
      end
    end
    check("ignore.latency", firstLat, LAT);
    check("ignore.doneCount", doneCount, 1);

    // Random jobs against the model.
    for (int n = 0; n < 40; n++) begin
      mode = int'($urandom_range(2));
      rj.s00 = rndVal(mode, 1'b1); rj.s01 = rndVal(mode, 1'b0);
      rj.s10 = rndVal(mode, 1'b0); rj.s11 = rndVal(mode, 1'b1);
      rj.r11 = rndVal(mode, 1'b1); rj.r12 = rndVal(mode, 1'b0);
      rj.r21 = rndVal(mode, 1'b0); rj.r22 = rndVal(mode, 1'b1);
      re = model(rj);
      runJob($sformatf("rand%0d", n), rj, re);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
